// File: rtl/itd_pkg.sv
// ---------------------------------------------------------------------------
// itd_pkg
// Shared constants and types for the inter-channel delay (ITD) estimator.
//   MAX_LAG   : largest lag searched in either direction, in samples
//   NUM_LAGS  : number of lags searched (-MAX_LAG..+MAX_LAG)
//   PROD_BITS : upper sample bits kept for the correlation multiplier
//   LAG_WIDTH : width of the signed lag result
//   itdState_t: controller states
// ---------------------------------------------------------------------------
package itd_pkg;

  localparam int MAX_LAG   = 15;
  localparam int NUM_LAGS  = 2 * MAX_LAG + 1;
  localparam int PROD_BITS = 12;
  localparam int LAG_WIDTH = $clog2(NUM_LAGS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_R,
    MAC,
    SEARCH
  } itdState_t;

endpackage

// File: rtl/axis_itd_estimator_history.sv
// ---------------------------------------------------------------------------
// sample_history
// DEPTH x WIDTH shift register holding the most recent samples of one
// channel, index 0 = newest. One tap is read combinationally.
//   clk      : clock
//   i_clear  : synchronous clear of every entry
//   i_shift  : push i_data in at index 0, everything else moves one older
//   i_data   : sample to push
//   i_tapIdx : entry to read
//   o_tap    : contents of entry i_tapIdx
// ---------------------------------------------------------------------------
module sample_history
  import itd_pkg::*;
#(
  parameter int DEPTH = NUM_LAGS,
  parameter int WIDTH = PROD_BITS
) (
  input  logic                     clk,
  input  logic                     i_clear,
  input  logic                     i_shift,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(DEPTH)-1:0] i_tapIdx,
  output logic [WIDTH-1:0]         o_tap
);

  logic [WIDTH-1:0] r_taps [DEPTH];

  // Clear wins over shift so a reset mid-frame leaves an empty history.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else if (i_shift) begin
      r_taps[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign o_tap = r_taps[i_tapIdx];

endmodule

// File: rtl/axis_itd_estimator.sv
// ---------------------------------------------------------------------------
// axis_itd_estimator
// Cross-correlates left against right over a window of 2^WINDOW_LOG2 stereo
// frames and reports the lag with the largest correlation.
//   clk, reset                     : clock, synchronous active-high reset
//   s_axis_data/valid/ready/last   : interleaved stereo input, last=1 is right
//   m_axis_lag                     : signed peak lag, positive = right lags left
//   m_axis_peak                    : correlation value at that lag
//   m_axis_valid/ready             : result handshake
//   overrun                        : sticky, an unaccepted result was replaced
// ---------------------------------------------------------------------------
module axis_itd_estimator #(
  parameter int DATA_WIDTH  = 24,
  parameter int MAX_LAG     = itd_pkg::MAX_LAG,
  parameter int PROD_BITS   = itd_pkg::PROD_BITS,
  parameter int WINDOW_LOG2 = 10,
  parameter int ACC_WIDTH   = 2 * PROD_BITS + WINDOW_LOG2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [DATA_WIDTH-1:0]               s_axis_data,
  input  logic                                s_axis_valid,
  output logic                                s_axis_ready,
  input  logic                                s_axis_last,
  output logic signed [itd_pkg::LAG_WIDTH-1:0] m_axis_lag,
  output logic signed [ACC_WIDTH-1:0]         m_axis_peak,
  output logic                                m_axis_valid,
  input  logic                                m_axis_ready,
  output logic                                overrun
);

  import itd_pkg::*;

  localparam int NLAGS = 2 * MAX_LAG + 1;
  localparam int CNT_W = $clog2(NLAGS);

  itdState_t r_state, w_nextState;

  logic [CNT_W-1:0]            r_cycleCnt;
  logic [WINDOW_LOG2-1:0]      r_frameCnt;
  logic [PROD_BITS-1:0]        r_leftPending;
  logic signed [ACC_WIDTH-1:0] r_acc [NLAGS];
  logic signed [ACC_WIDTH-1:0] r_bestVal;
  logic [CNT_W-1:0]            r_bestIdx;

  logic                          w_inAccept;
  logic                          w_historyShift;
  logic                          w_macLast;
  logic                          w_searchLast;
  logic                          w_outAccept;
  logic [PROD_BITS-1:0]          w_leftTap;
  logic [PROD_BITS-1:0]          w_rightTap;
  logic signed [2*PROD_BITS-1:0] w_product;
  logic signed [ACC_WIDTH-1:0]   w_productExt;
  logic                          w_candBetter;
  logic signed [ACC_WIDTH-1:0]   w_candVal;
  logic [CNT_W-1:0]              w_candIdx;
  logic [LAG_WIDTH-1:0]          w_candLag;
  logic                          w_unusedLowBits;

  // Only the upper PROD_BITS of each sample feed the correlator.
  assign w_unusedLowBits = ^s_axis_data[DATA_WIDTH-PROD_BITS-1:0];

  assign w_inAccept     = s_axis_valid & s_axis_ready;
  assign w_historyShift = w_inAccept & s_axis_last & (r_state == WAIT_R);
  assign w_macLast      = (r_state == MAC) && (r_cycleCnt == CNT_W'(NLAGS - 1));
  assign w_searchLast   = (r_state == SEARCH) && (r_cycleCnt == CNT_W'(NLAGS - 1));
  assign w_outAccept    = m_axis_valid & m_axis_ready;

  // The right channel is tapped at the centre and the left channel walks
  // across the history, so accumulator i pairs right[n-MAX_LAG] with
  // left[n-i]; a right channel delayed by k samples peaks at i = MAX_LAG+k.
  sample_history #(.DEPTH(NLAGS), .WIDTH(PROD_BITS)) u_leftHistory (
    .clk      (clk),
    .i_clear  (reset),
    .i_shift  (w_historyShift),
    .i_data   (r_leftPending),
    .i_tapIdx (r_cycleCnt),
    .o_tap    (w_leftTap)
  );

  sample_history #(.DEPTH(NLAGS), .WIDTH(PROD_BITS)) u_rightHistory (
    .clk      (clk),
    .i_clear  (reset),
    .i_shift  (w_historyShift),
    .i_data   (s_axis_data[DATA_WIDTH-1 -: PROD_BITS]),
    .i_tapIdx (CNT_W'(MAX_LAG)),
    .o_tap    (w_rightTap)
  );

  assign w_product    = $signed(w_leftTap) * $signed(w_rightTap);
  assign w_productExt = {{(ACC_WIDTH - 2*PROD_BITS){w_product[2*PROD_BITS-1]}}, w_product};

  // Argmax step: the first scanned entry seeds the best value, later ones
  // replace it only when strictly larger, so ties keep the most negative lag.
  assign w_candBetter = (r_cycleCnt == '0) || (r_acc[r_cycleCnt] > r_bestVal);
  assign w_candVal    = w_candBetter ? r_acc[r_cycleCnt] : r_bestVal;
  assign w_candIdx    = w_candBetter ? r_cycleCnt : r_bestIdx;
  assign w_candLag    = LAG_WIDTH'(w_candIdx) - LAG_WIDTH'(MAX_LAG);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic: a frame is a left word then a right word; a stray right
  // word in IDLE is dropped so the pair realigns.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_inAccept && !s_axis_last) w_nextState = WAIT_R;
      WAIT_R:  if (w_inAccept && s_axis_last)  w_nextState = MAC;
      MAC:     if (w_macLast) w_nextState = (&r_frameCnt) ? SEARCH : IDLE;
      SEARCH:  if (w_searchLast) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: input is accepted only while collecting a frame.
  always_comb begin
    s_axis_ready = 1'b0;
    if (r_state == IDLE || r_state == WAIT_R) s_axis_ready = 1'b1;
  end

  // Lag/scan counter shared by MAC and SEARCH, and the window frame counter
  // that wraps naturally at 2^WINDOW_LOG2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycleCnt <= '0;
      r_frameCnt <= '0;
    end else begin
      if (r_state == MAC || r_state == SEARCH)
        r_cycleCnt <= (r_cycleCnt == CNT_W'(NLAGS - 1)) ? '0 : r_cycleCnt + 1'b1;
      if (w_macLast) r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  // Latest left word waiting for its right partner; a second left word
  // simply replaces it.
  always_ff @(posedge clk) begin
    if (reset)                           r_leftPending <= '0;
    else if (w_inAccept && !s_axis_last) r_leftPending <= s_axis_data[DATA_WIDTH-1 -: PROD_BITS];
  end

  // One multiply-accumulate per MAC cycle; the array is emptied once the
  // window result has been captured.
  always_ff @(posedge clk) begin
    if (reset || w_searchLast) begin
      for (int i = 0; i < NLAGS; i++) r_acc[i] <= '0;
    end else if (r_state == MAC) begin
      r_acc[r_cycleCnt] <= r_acc[r_cycleCnt] + w_productExt;
    end
  end

  // Running best during the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bestVal <= '0;
      r_bestIdx <= '0;
    end else if (r_state == SEARCH) begin
      r_bestVal <= w_candVal;
      r_bestIdx <= w_candIdx;
    end
  end

  // Result register. A new result always wins over a same-cycle accept, and
  // replacing a still-valid result flags the loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_lag   <= '0;
      m_axis_peak  <= '0;
      m_axis_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (w_searchLast) begin
      m_axis_lag   <= w_candLag;
      m_axis_peak  <= w_candVal;
      m_axis_valid <= 1'b1;
      if (m_axis_valid) overrun <= 1'b1;
    end else if (w_outAccept) begin
      m_axis_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_itd_estimator.sv
// ---------------------------------------------------------------------------
// tb_axis_itd_estimator
// Drives stereo frames into axis_itd_estimator and checks every window
// result against a correlation model kept here.
// ---------------------------------------------------------------------------
module tb_axis_itd_estimator;

  localparam int DW  = 24;
  localparam int ML  = 15;
  localparam int PB  = 12;
  localparam int WL  = 4;
  localparam int AW  = 2 * PB + WL;
  localparam int WIN = 1 << WL;
  localparam int NL  = 2 * ML + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DW-1:0]        s_axis_data;
  logic                 s_axis_valid;
  logic                 s_axis_ready;
  logic                 s_axis_last;
  logic signed [5:0]    m_axis_lag;
  logic signed [AW-1:0] m_axis_peak;
  logic                 m_axis_valid;
  logic                 m_axis_ready;
  logic                 overrun;

  typedef struct {
    int     lag;
    longint peak;
    bit     ovr;
  } expResult_t;

  expResult_t expQ[$];
  int         lSamp[$];
  int         rSamp[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  logic [DW-1:0] prbs[$];

  axis_itd_estimator #(
    .DATA_WIDTH (DW),
    .MAX_LAG    (ML),
    .PROD_BITS  (PB),
    .WINDOW_LOG2(WL),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis_data (s_axis_data),
    .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready),
    .s_axis_last (s_axis_last),
    .m_axis_lag  (m_axis_lag),
    .m_axis_peak (m_axis_peak),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .overrun     (overrun)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Upper PB bits of a word as a signed integer, which is what the
  // correlator multiplies.
  function automatic int topBits(input logic [DW-1:0] d);
    logic signed [PB-1:0] t;
    t = d[DW-1 -: PB];
    return int'(t);
  endfunction

  // Reference: correlation at lag k over the window is the sum of
  // left[f-ML-k] * right[f-ML] for each frame f, with samples before reset
  // taken as zero. Argmax keeps the first (most negative) lag on ties. A
  // result still waiting while the sink stalls is superseded and flagged.
  task automatic computeWindow();
    int         n;
    longint     best;
    int         bestLag;
    expResult_t e;
    n = lSamp.size();
    best = 0;
    bestLag = -ML;
    for (int k = -ML; k <= ML; k++) begin
      longint s;
      s = 0;
      for (int f = n - WIN; f < n; f++) begin
        int li, ri;
        li = f - ML - k;
        ri = f - ML;
        if (li >= 0 && ri >= 0) s += longint'(lSamp[li]) * longint'(rSamp[ri]);
      end
      if (k == -ML || s > best) begin
        best = s;
        bestLag = k;
      end
    end
    e.lag = bestLag;
    e.peak = best;
    e.ovr = 1'b0;
    if (!m_axis_ready && expQ.size() > 0) begin
      void'(expQ.pop_back());
      e.ovr = 1'b1;
    end
    expQ.push_back(e);
  endtask

  // Records one accepted frame in the model.
  task automatic modelFrame(input logic [DW-1:0] lw, input logic [DW-1:0] rw);
    lSamp.push_back(topBits(lw));
    rSamp.push_back(topBits(rw));
    if (lSamp.size() % WIN == 0) computeWindow();
  endtask

  // Offers one word and returns just after the handshake edge.
  task automatic sendWord(input logic [DW-1:0] d, input logic l);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    s_axis_data = d;
    s_axis_last = l;
    s_axis_valid = 1'b1;
    while (!s_axis_ready && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 300) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL readyTimeout: got ready=0 for %0d cycles, expected ready", waitCnt);
    end
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  // Measures how long input is stalled after a right word; at a window end
  // the result must be presented as soon as input reopens.
  task automatic checkFrameTiming(input bit windowEnd);
    int lowCnt;
    lowCnt = 0;
    @(negedge clk);
    while (!s_axis_ready && lowCnt < 300) begin
      lowCnt++;
      @(negedge clk);
    end
    checkOutput(windowEnd ? "windowReadyLow" : "frameReadyLow", lowCnt, windowEnd ? 2 * NL : NL);
    if (windowEnd) checkOutput("validRise", m_axis_valid, 1);
  endtask

  // One left/right frame with model update and stall timing check.
  task automatic applyStimulus(input logic [DW-1:0] lw, input logic [DW-1:0] rw);
    sendWord(lw, 1'b0);
    sendWord(rw, 1'b1);
    modelFrame(lw, rw);
    checkFrameTiming(lSamp.size() % WIN == 0);
  endtask

  // Waits for every predicted result to be consumed by the monitor.
  task automatic drainResults();
    int w;
    w = 0;
    while (expQ.size() > 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL resultMissing: got no result, expected %0d more", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic doReset();
    drainResults();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lSamp.delete();
    rSamp.delete();
  endtask

  task automatic makePrbs(input int count);
    prbs.delete();
    for (int i = 0; i < count; i++)
      prbs.push_back(($urandom_range(0, 1) == 1) ? 24'h400000 : 24'hC00000);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "Ready"},   s_axis_ready, 1);
    checkOutput({tag, "Valid"},   m_axis_valid, 0);
    checkOutput({tag, "Lag"},     longint'(m_axis_lag), 0);
    checkOutput({tag, "Peak"},    longint'(m_axis_peak), 0);
    checkOutput({tag, "Overrun"}, overrun, 0);
  endtask

  // Monitor: every accepted result is matched against the oldest prediction.
  always @(negedge clk) begin
    expResult_t e;
    if (!reset && m_axis_valid && m_axis_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedResult: got lag %0d peak %0d, expected none", m_axis_lag, m_axis_peak);
      end else begin
        e = expQ.pop_front();
        checkOutput("resultLag", longint'(m_axis_lag), e.lag);
        checkOutput("resultPeak", longint'(m_axis_peak), e.peak);
        checkOutput("resultOverrun", overrun, e.ovr);
      end
    end
  end

  // Scenario sequence.
  initial begin
    reset = 1'b1;
    s_axis_data = '0;
    s_axis_valid = 1'b0;
    s_axis_last = 1'b0;
    m_axis_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("reset");

    $display("[TB] resync");
    sendWord(24'h300000, 1'b1);
    @(negedge clk);
    checkOutput("resyncStillReady", s_axis_ready, 1);
    sendWord(24'hC00000, 1'b0);
    sendWord(24'h400000, 1'b0);
    sendWord(24'h300000, 1'b1);
    modelFrame(24'h400000, 24'h300000);
    checkFrameTiming(1'b0);
    for (int i = 1; i < WIN; i++) applyStimulus('0, '0);

    $display("[TB] known delay +3");
    doReset();
    makePrbs(2 * WIN);
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(prbs[i], (i >= 3) ? prbs[i-3] : '0);

    $display("[TB] all-zero input");
    doReset();
    for (int i = 0; i < WIN; i++) applyStimulus('0, '0);

    $display("[TB] random data");
    doReset();
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(DW'($urandom()), DW'($urandom()));

    $display("[TB] zero delay");
    doReset();
    makePrbs(2 * WIN);
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(prbs[i], prbs[i]);

    $display("[TB] reset during MAC");
    drainResults();
    for (int i = 0; i < 5; i++) applyStimulus(prbs[i], prbs[i]);
    sendWord(24'h400000, 1'b0);
    sendWord(24'h400000, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    lSamp.delete();
    rSamp.delete();
    @(negedge clk);
    checkIdleOutputs("midReset");
    makePrbs(2 * WIN);
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(prbs[i], prbs[i]);

    $display("[TB] backpressure");
    doReset();
    m_axis_ready = 1'b0;
    for (int i = 0; i < 2 * WIN; i++) applyStimulus(DW'($urandom()), DW'($urandom()));
    checkOutput("stallValid", m_axis_valid, 1);
    checkOutput("stallOverrun", overrun, 1);
    @(posedge clk);
    #1;
    m_axis_ready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_ready = 1'b0;
    @(negedge clk);
    checkOutput("acceptValid", m_axis_valid, 0);
    checkOutput("acceptOverrun", overrun, 0);
    m_axis_ready = 1'b1;

    drainResults();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
